// File: rtl/popcount_pipe.sv
// popcount_pipe: pipelined adder-tree popcount with valid/ready handshake and saturating running total
module popcount_pipe #(
    parameter int N_IN = 16,
    parameter int ACC_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_IN-1:0]               in_data,
    input  logic                          in_acc_clr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(N_IN+1)-1:0]     out_count,
    output logic [ACC_W-1:0]              out_acc,
    output logic                          out_sat
);
    localparam int CNT_W = $clog2(N_IN + 1);
    localparam int LVL = $clog2(N_IN);
    localparam int P = 1 << LVL;
    localparam int W = LVL + 1;
    logic [W-1:0] s [LVL+1][P];
    logic v [LVL+1];
    logic c [LVL+1];
    logic [P-1:0] pad;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] cnt_x;
    logic [ACC_W:0] sum;
    logic [ACC_W-1:0] acc_nxt;
    logic adv;
    always_comb begin
        adv = ~out_valid | out_ready;
        pad = P'(in_data);
        cnt = s[LVL][0][CNT_W-1:0];
        cnt_x = ACC_W'(cnt);
        sum = {1'b0, out_acc} + {1'b0, cnt_x};
        acc_nxt = c[LVL] ? cnt_x : (sum[ACC_W] ? '1 : sum[ACC_W-1:0]);
    end
    assign in_ready = adv;
    // level k holds P>>k live sums in its low entries; the upper entries stay zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= LVL; k++) begin
                v[k] <= 1'b0;
                c[k] <= 1'b0;
                for (int j = 0; j < P; j++) s[k][j] <= '0;
            end
            out_valid <= 1'b0;
            out_count <= '0;
            out_acc <= '0;
            out_sat <= 1'b0;
        end else if (adv) begin
            v[0] <= in_valid;
            c[0] <= in_acc_clr;
            for (int j = 0; j < P; j++) s[0][j] <= W'(pad[j]);
            for (int k = 1; k <= LVL; k++) begin
                v[k] <= v[k-1];
                c[k] <= c[k-1];
                for (int j = 0; j < P / 2; j++) s[k][j] <= s[k-1][2*j] + s[k-1][2*j+1];
                for (int j = P / 2; j < P; j++) s[k][j] <= '0;
            end
            out_valid <= v[LVL];
            if (v[LVL]) begin
                out_count <= cnt;
                out_acc <= acc_nxt;
                out_sat <= (acc_nxt == '1);
            end
        end
    end
endmodule
